task_repeat: RTL and testbench
==============================

TASK_REPEAT -- requirements
Module: task_repeat

Interface
REQ-001 SHALL have parameter TASKS_W, default 16, meaning width of the decoded task word.
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the repeat count and iteration index.
REQ-003 SHALL have parameter TASK_RPT_LOAD, TASKS_W bits, default 0, meaning the task mask that loads a repeat count; 0 disables loading.
REQ-004 SHALL have parameter TASK_RPT, TASKS_W bits, default 0, meaning the task mask of repeated (PC-holding) tasks; 0 disables repeating.
REQ-005 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port tasks, input, TASKS_W, the decoded task word of the current microinstruction.
REQ-008 SHALL have port rpt_cnt_in, input, CNT_W, the iteration count N, sampled when a load task is active.
REQ-009 SHALL have port repeat_done, output, 1, combinational; high on the final iteration of a repeated task, which releases the PC sequencer.
REQ-010 SHALL have port rpt_busy, output, 1, registered; high while a loaded count is pending or running.
REQ-011 SHALL have port rpt_idx, output, CNT_W, registered; zero-based index of the current iteration.
REQ-012 SHALL have port rpt_err, output, 1, registered sticky protocol-error flag.

Function
REQ-013 SHALL define load_act = (TASK_RPT_LOAD != 0) && |(tasks & TASK_RPT_LOAD), and rpt_act = (TASK_RPT != 0) && |(tasks & TASK_RPT).
REQ-014 SHALL implement a 3-state machine: IDLE, ARMED (count loaded, repeat not yet started), RUN (repeat in progress).
REQ-015 SHALL hold an internal remaining-count register cnt (CNT_W bits), meaning iterations left after the current one.
REQ-016 SHALL, on load_act, set cnt <= N-1 (N = rpt_cnt_in; N = 0 is treated as 1, so cnt <= 0), set rpt_idx <= 0, and enter ARMED, from any state.
REQ-017 SHALL drive repeat_done = rpt_act && (state == IDLE || cnt == 0); repeat_done SHALL be 0 whenever rpt_act is 0.
REQ-018 SHALL, when rpt_act is high in ARMED or RUN with cnt != 0 and no load_act: cnt <= cnt-1, rpt_idx <= rpt_idx+1, state RUN.
REQ-019 SHALL, when rpt_act is high in ARMED or RUN with cnt == 0 and no load_act: state IDLE, rpt_idx <= 0.
REQ-020 SHALL, when rpt_act is high in IDLE: assert repeat_done (single execution), set rpt_err, and stay IDLE.
REQ-021 SHALL, when in RUN with rpt_act low and no load_act (repeat aborted): set rpt_err, state IDLE, rpt_idx <= 0.
REQ-022 SHALL stay in ARMED while rpt_act and load_act are both low; cnt and rpt_idx hold.
REQ-023 SHALL, on load_act and rpt_act in the same cycle: compute repeat_done from the pre-load state and cnt; the load (REQ-016) sets the next state; rpt_err is unaffected unless REQ-020 applies.
REQ-024 SHALL drive rpt_busy = (state != IDLE).
REQ-025 SHALL use modulo-2^CNT_W arithmetic; cnt never decrements below 0, and rpt_idx never exceeds N-1.
REQ-026 SHALL keep rpt_err set until reset; no other event clears it.
REQ-027 SHALL, with N iterations loaded and rpt_act held, give exactly N cycles of rpt_act, with repeat_done high only on the N-th.

Reset
REQ-028 SHALL, on reset high, immediately set state IDLE, cnt 0, rpt_idx 0 and rpt_err 0; rpt_busy is then 0.
REQ-029 SHALL, when reset is asserted mid-RUN, abandon the count; the first rpt_act after reset behaves per REQ-020.
REQ-030 SHALL resume normal operation on the first clk edge after reset deasserts.

Verification
REQ-031 SHALL cover: load N=3, then rpt_act for 3 cycles -> repeat_done 0,0,1; rpt_idx 0,1,2; then IDLE, rpt_busy 0, rpt_err 0.
REQ-032 SHALL cover: load N=0 and N=1, each followed by rpt_act -> repeat_done 1 on the first cycle; state IDLE next.
REQ-033 SHALL cover: rpt_act with no prior load -> repeat_done 1, rpt_err 1, which stays set across later good loops.
REQ-034 SHALL cover: load N=5, 2 rpt_act cycles, then rpt_act low -> rpt_err 1, IDLE, rpt_idx 0.
REQ-035 SHALL cover: load N=4, 1 rpt_act cycle, then load N=2 together with rpt_act -> repeat_done 0, ARMED, cnt 1, rpt_idx 0; the next 2 rpt_act cycles give repeat_done 0,1.
REQ-036 SHALL cover: CNT_W=8, N=255 full run (repeat_done only on cycle 255, final rpt_idx 254); assert reset at cycle 100 -> all outputs 0 immediately.

Source files
------------

// File: rtl/task_repeat.sv
// Repeat-count sequencer: a load task arms an iteration count, and a repeated task holds the PC
// until the final iteration, where repeat_done releases it.
module task_repeat #(
   parameter int unsigned           TASKS_W       = 16,
   parameter int unsigned           CNT_W         = 8,
   parameter logic [TASKS_W-1:0]    TASK_RPT_LOAD = '0,
   parameter logic [TASKS_W-1:0]    TASK_RPT      = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [TASKS_W-1:0] tasks,
   input  logic [CNT_W-1:0]   rpt_cnt_in,
   output logic               repeat_done,
   output logic               rpt_busy,
   output logic [CNT_W-1:0]   rpt_idx,
   output logic               rpt_err
);

   typedef enum logic [1:0] {StIdle, StArmed, StRun} state_e;

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic             load_act;
   logic             rpt_act;
   logic [CNT_W-1:0] load_cnt;

   assign load_act = (TASK_RPT_LOAD != '0) && (|(tasks & TASK_RPT_LOAD));
   assign rpt_act  = (TASK_RPT != '0) && (|(tasks & TASK_RPT));

   // A count of zero still executes the task once.
   assign load_cnt = (rpt_cnt_in == '0) ? '0 : rpt_cnt_in - CNT_W'(1);

   // Evaluated on the pre-load state, so a load in the same cycle does not affect it.
   assign repeat_done = rpt_act && ((state == StIdle) || (cnt == '0));
   assign rpt_busy    = (state != StIdle);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= StIdle;
         cnt     <= '0;
         rpt_idx <= '0;
         rpt_err <= 1'b0;
      end else begin
         if (rpt_act && (state == StIdle)) begin
            rpt_err <= 1'b1;
         end
         if (load_act) begin
            state   <= StArmed;
            cnt     <= load_cnt;
            rpt_idx <= '0;
         end else begin
            unique case (state)
               StIdle: begin
                  state <= StIdle;
               end
               StArmed, StRun: begin
                  if (rpt_act) begin
                     if (cnt != '0) begin
                        state   <= StRun;
                        cnt     <= cnt - CNT_W'(1);
                        rpt_idx <= rpt_idx + CNT_W'(1);
                     end else begin
                        state   <= StIdle;
                        rpt_idx <= '0;
                     end
                  end else if (state == StRun) begin
                     // Repeated task dropped before its last iteration.
                     state   <= StIdle;
                     cnt     <= '0;
                     rpt_idx <= '0;
                     rpt_err <= 1'b1;
                  end
               end
               default: begin
                  state   <= StIdle;
                  cnt     <= '0;
                  rpt_idx <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_task_repeat.sv
// Scoreboard bench for task_repeat: each driven cycle queues its expected outputs, and a
// negedge monitor pops and compares them.
module tb_task_repeat;

   localparam logic [15:0] T_NONE = 16'h0000;
   localparam logic [15:0] T_LOAD = 16'h0001;
   localparam logic [15:0] T_RPT  = 16'h0002;
   localparam logic [15:0] T_BOTH = 16'h0003;
   localparam logic [15:0] T_NOISE = 16'h0100;

   logic        clk;
   logic        reset;
   logic [15:0] tasks;
   logic [7:0]  rpt_cnt_in;
   logic        repeat_done;
   logic        rpt_busy;
   logic [7:0]  rpt_idx;
   logic        rpt_err;

   typedef struct {
      logic         done;
      logic         busy;
      logic [7:0]   idx;
      logic         err;
      logic [127:0] name;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task_repeat #(
      .TASKS_W       (16),
      .CNT_W         (8),
      .TASK_RPT_LOAD (T_LOAD),
      .TASK_RPT      (T_RPT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tasks       (tasks),
      .rpt_cnt_in  (rpt_cnt_in),
      .repeat_done (repeat_done),
      .rpt_busy    (rpt_busy),
      .rpt_idx     (rpt_idx),
      .rpt_err     (rpt_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs and queue the outputs expected during that cycle.
   task automatic step(input logic rst, input logic [15:0] t, input logic [7:0] n,
                       input logic d, input logic b, input logic [7:0] i, input logic e,
                       input logic [127:0] nm);
      exp_t x;
      @(posedge clk);
      #1;
      reset      = rst;
      tasks      = t;
      rpt_cnt_in = n;
      x.done = d;
      x.busy = b;
      x.idx  = i;
      x.err  = e;
      x.name = nm;
      q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t x;
         x = q.pop_front();
         n_checks++;
         if ({repeat_done, rpt_busy, rpt_idx, rpt_err} !== {x.done, x.busy, x.idx, x.err}) begin
            n_fail++;
            $display("FAIL %0s: got done=%b busy=%b idx=%0d err=%b, want done=%b busy=%b idx=%0d err=%b",
                     x.name, repeat_done, rpt_busy, rpt_idx, rpt_err,
                     x.done, x.busy, x.idx, x.err);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      tasks      = T_NONE;
      rpt_cnt_in = 8'd0;

      step(1, T_NONE, 0, 0, 0, 0, 0, "reset");
      step(0, T_NONE, 0, 0, 0, 0, 0, "post_reset");

      // N=3 loop; an unrelated task bit must not act
      step(0, T_LOAD, 3, 0, 0, 0, 0, "n3_load");
      step(0, T_RPT | T_NOISE, 0, 0, 1, 0, 0, "n3_it0");
      step(0, T_RPT, 0, 0, 1, 1, 0, "n3_it1");
      step(0, T_RPT, 0, 1, 1, 2, 0, "n3_it2");
      step(0, T_NOISE, 0, 0, 0, 0, 0, "n3_idle");

      // N=0 and N=1 both run once
      step(0, T_LOAD, 0, 0, 0, 0, 0, "n0_load");
      step(0, T_RPT, 0, 1, 1, 0, 0, "n0_it0");
      step(0, T_NONE, 0, 0, 0, 0, 0, "n0_idle");
      step(0, T_LOAD, 1, 0, 0, 0, 0, "n1_load");
      step(0, T_RPT, 0, 1, 1, 0, 0, "n1_it0");
      step(0, T_NONE, 0, 0, 0, 0, 0, "n1_idle");

      // ARMED holds while idle
      step(0, T_LOAD, 2, 0, 0, 0, 0, "arm_load");
      step(0, T_NONE, 0, 0, 1, 0, 0, "arm_hold0");
      step(0, T_NONE, 0, 0, 1, 0, 0, "arm_hold1");
      step(0, T_RPT, 0, 0, 1, 0, 0, "arm_it0");
      step(0, T_RPT, 0, 1, 1, 1, 0, "arm_it1");
      step(0, T_NONE, 0, 0, 0, 0, 0, "arm_idle");

      // Reload during a run, together with rpt_act
      step(0, T_LOAD, 4, 0, 0, 0, 0, "rl_load4");
      step(0, T_RPT, 0, 0, 1, 0, 0, "rl_it0");
      step(0, T_BOTH, 2, 0, 1, 1, 0, "rl_load2");
      step(0, T_RPT, 0, 0, 1, 0, 0, "rl_it0b");
      step(0, T_RPT, 0, 1, 1, 1, 0, "rl_it1b");
      step(0, T_NONE, 0, 0, 0, 0, 0, "rl_idle");

      // Abort mid-run
      step(0, T_LOAD, 5, 0, 0, 0, 0, "ab_load");
      step(0, T_RPT, 0, 0, 1, 0, 0, "ab_it0");
      step(0, T_RPT, 0, 0, 1, 1, 0, "ab_it1");
      step(0, T_NONE, 0, 0, 1, 2, 0, "ab_drop");
      step(0, T_NONE, 0, 0, 0, 0, 1, "ab_err");

      step(1, T_NONE, 0, 0, 0, 0, 0, "rst_clr_err");
      step(0, T_NONE, 0, 0, 0, 0, 0, "rst_rel");

      // rpt_act with no load, then sticky error across good loops
      step(0, T_RPT, 0, 1, 0, 0, 0, "noload_rpt");
      step(0, T_NONE, 0, 0, 0, 0, 1, "noload_err");
      step(0, T_BOTH, 1, 1, 0, 0, 1, "both_idle");
      step(0, T_RPT, 0, 1, 1, 0, 1, "both_it0");
      step(0, T_LOAD, 2, 0, 0, 0, 1, "sticky_load");
      step(0, T_RPT, 0, 0, 1, 0, 1, "sticky_it0");
      step(0, T_RPT, 0, 1, 1, 1, 1, "sticky_it1");
      step(0, T_NONE, 0, 0, 0, 0, 1, "sticky_idle");

      step(1, T_NONE, 0, 0, 0, 0, 0, "rst_full");
      step(0, T_NONE, 0, 0, 0, 0, 0, "rst_full_rel");

      // Full N=255 run
      step(0, T_LOAD, 255, 0, 0, 0, 0, "full_load");
      for (int i = 0; i < 255; i++) begin
         step(0, T_RPT, 0, (i == 254), 1, 8'(i), 0, "full_it");
      end
      step(0, T_NONE, 0, 0, 0, 0, 0, "full_idle");

      // Reset asserted on cycle 100 of another N=255 run
      step(0, T_LOAD, 255, 0, 0, 0, 0, "mid_load");
      for (int i = 0; i < 99; i++) begin
         step(0, T_RPT, 0, 0, 1, 8'(i), 0, "mid_it");
      end
      step(1, T_NONE, 0, 0, 0, 0, 0, "mid_reset");
      step(0, T_NONE, 0, 0, 0, 0, 0, "mid_rel");
      step(0, T_RPT, 0, 1, 0, 0, 0, "mid_rpt_idle");
      step(0, T_NONE, 0, 0, 0, 0, 1, "mid_err");

      @(posedge clk);
      @(posedge clk);
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
